spi_avalon_seq_master: RTL
==========================

Name: spi_avalon_seq_master

Overview:
- Avalon-MM master that sits directly upstream of the SPI Avalon slave, in the same clock domain.
- Accepts 32-bit SPI words from a local stream and buffers them in a command FIFO.
- For each word it writes the word to the slave, waits for the slave's irq, reads the received word back, and returns it on a result stream.
- Removes the need for a CPU to run the per-word write/irq/read sequence.

Parameters:
- FIFO_DEPTH, 8: command FIFO entries; power of two, minimum 2.
- WR_ADDR, 8'h00: Avalon address used for the TX-data write.
- RD_ADDR, 8'h04: Avalon address used for the RX-data read.
- TIMEOUT_CYCLES, 1024: irq wait limit; used only when SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, same clock as the SPI Avalon slave.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command word valid.
- cmd_data  in  32  SPI word to transmit.
- cmd_ready  out  1  high when the FIFO is not full.
- res_valid  out  1  result word valid.
- res_data  out  32  word received from SPI.
- res_err  out  1  result is a timeout abort; res_data is 0.
- res_ready  in  1  result consumer ready.
- av_address  out  8  Avalon address.
- av_chip_select  out  1  Avalon chip select.
- av_write  out  1  Avalon write strobe.
- av_write_data  out  32  Avalon write data.
- av_read  out  1  Avalon read strobe.
- av_read_data  in  32  Avalon read data.
- av_wait_request  in  1  slave stall.
- irq  in  1  slave transfer-complete, level.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. FIFO empty, FSM in IDLE, timeout counter 0.
- Command FIFO:
  - Push on cmd_valid & cmd_ready.
  - Pop when the FSM leaves IDLE.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - When full, cmd_ready = 0 and a push is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 states wide.
- FSM states: IDLE, WR, WAIT_IRQ, RD, OUT.
- IDLE:
  - Condition: FIFO not empty and res_valid = 0.
  - Action: pop the head word; register av_write_data = word, av_address = WR_ADDR, av_chip_select = 1, av_write = 1.
  - Next state: WR.
- WR:
  - Hold all Avalon outputs stable while av_wait_request = 1.
  - In the first cycle with av_wait_request = 0, the write is accepted. Next cycle: av_write = 0, av_chip_select = 0, state WAIT_IRQ.
- WAIT_IRQ:
  - On irq = 1: drive av_address = RD_ADDR, av_chip_select = 1, av_read = 1; state RD.
  - An irq already high on entry is honoured immediately, giving 1 cycle in WAIT_IRQ.
- RD:
  - Hold while av_wait_request = 1.
  - On the cycle av_wait_request = 0, capture av_read_data into res_data.
  - Next cycle: drop av_read/av_chip_select, res_valid = 1, res_err = 0, state OUT.
- OUT:
  - res_valid stays high until res_valid & res_ready.
  - On that handshake: res_valid = 0, state IDLE.
  - res_data and res_err are stable while valid.
- Reads of the slave always follow the irq, so irq deasserts as a side effect of the read. The block never issues a new write before the previous read completes.
- Minimum latency, cmd push to res_valid, with zero wait states and immediate irq: 1 cycle (FIFO) + 1 (IDLE) + 1 (WR) + 1 (WAIT_IRQ) + 1 (RD) = 5 cycles.
- At most one Avalon strobe is high at a time; av_write and av_read are never both 1.
- Reset asserted mid-transfer: everything returns to reset values on the next edge, FIFO contents are discarded, and any in-flight Avalon access is dropped.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_IRQ and clears on entry.
  - When it reaches TIMEOUT_CYCLES-1 with irq still 0, the FSM goes to OUT with res_data = 0 and res_err = 1. No read is issued.
  - irq and the timeout in the same cycle: irq wins.
- Not defined: no counter exists, WAIT_IRQ waits indefinitely, and res_err is tied to 0.

Decomposition:
- Package spi_seq_pkg holds:
  - FSM state encoding (5 states, 3 bits).
  - Default address constants WR_ADDR/RD_ADDR.
  - DATA_W = 32 and AV_ADDR_W = 8.
- One sub-module, spi_seq_cmd_fifo: synchronous FIFO, width DATA_W, depth FIFO_DEPTH, with full/empty/count outputs.

Test Plan:
- Single word, zero wait, irq 2 cycles after the write: cmd 32'hA5A5_1234 -> av write at addr 0x00 with that data, then read at 0x04; slave returns 32'h0000_00FF -> res_data = 0xFF, res_err = 0.
- Wait states: av_wait_request held high 3 cycles on both write and read -> address/data/strobes stable during the stall, exactly one write and one read accepted.
- FIFO full: push 9 words with FIFO_DEPTH = 8 and res_ready = 0 -> cmd_ready = 0 after 8 held words (one popped into the FSM); all words eventually returned in order with matching payloads.
- Backpressure: res_ready = 0 for 10 cycles -> res_valid held, no new Avalon access begins until the handshake.
- Reset during WAIT_IRQ with 3 words queued: reset 1 cycle -> all outputs 0, cmd_ready = 1, busy = 0; a later irq pulse produces no read.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 16, irq never asserted: -> res_valid with res_err = 1 and res_data = 0, exactly 16 cycles after entering WAIT_IRQ; no av_read issued.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI Avalon sequencing master.
package spi_seq_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned AV_ADDR_W = 8;

  localparam logic [AV_ADDR_W-1:0] DEF_WR_ADDR = 8'h00;
  localparam logic [AV_ADDR_W-1:0] DEF_RD_ADDR = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_WAIT_IRQ = 3'd2,
    ST_RD       = 3'd3,
    ST_OUT      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/spi_seq_cmd_fifo.sv
// Synchronous command FIFO; full/empty are registered flags derived from the next count.
module spi_seq_cmd_fifo
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic [DATA_W-1:0]                head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH + 1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [CNT_W-1:0]  count_nxt;

  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign head      = mem[rd_ptr];

  // Storage has no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/spi_avalon_seq_master.sv
// Runs the write / wait-irq / read sequence against the SPI Avalon slave for each queued word.
// Optional irq wait timeout enabled by defining SEQ_TIMEOUT_EN.
module spi_avalon_seq_master
  import spi_seq_pkg::*;
#(
  parameter int unsigned          FIFO_DEPTH     = 8,
  parameter logic [AV_ADDR_W-1:0] WR_ADDR        = DEF_WR_ADDR,
  parameter logic [AV_ADDR_W-1:0] RD_ADDR        = DEF_RD_ADDR,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [DATA_W-1:0]    cmd_data,
  output logic                 cmd_ready,
  output logic                 res_valid,
  output logic [DATA_W-1:0]    res_data,
  output logic                 res_err,
  input  logic                 res_ready,
  output logic [AV_ADDR_W-1:0] av_address,
  output logic                 av_chip_select,
  output logic                 av_write,
  output logic [DATA_W-1:0]    av_write_data,
  output logic                 av_read,
  input  logic [DATA_W-1:0]    av_read_data,
  input  logic                 av_wait_request,
  input  logic                 irq,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  seq_state_e           state;
  seq_state_e           state_nxt;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W-1:0]    fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 unused_ok;

  logic [AV_ADDR_W-1:0] addr_nxt;
  logic                 cs_nxt;
  logic                 wr_nxt;
  logic [DATA_W-1:0]    wdata_nxt;
  logic                 rd_nxt;
  logic                 rv_nxt;
  logic [DATA_W-1:0]    rdata_nxt;
  logic                 rerr_nxt;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  assign unused_ok = ^fifo_count;
`else
  assign unused_ok = ^{fifo_count, TIMEOUT_CYCLES};
`endif

  assign cmd_ready = ~fifo_full;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  spi_seq_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid & cmd_ready),
    .push_data (cmd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and next-output logic; every output holds unless a transition changes it.
  always_comb begin
    state_nxt = state;
    addr_nxt  = av_address;
    cs_nxt    = av_chip_select;
    wr_nxt    = av_write;
    wdata_nxt = av_write_data;
    rd_nxt    = av_read;
    rv_nxt    = res_valid;
    rdata_nxt = res_data;
    rerr_nxt  = res_err;
    fifo_pop  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmo_nxt   = tmo_cnt;
`endif

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && !res_valid) begin
          fifo_pop  = 1'b1;
          wdata_nxt = fifo_head;
          addr_nxt  = WR_ADDR;
          cs_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        if (!av_wait_request) begin
          wr_nxt    = 1'b0;
          cs_nxt    = 1'b0;
          state_nxt = ST_WAIT_IRQ;
`ifdef SEQ_TIMEOUT_EN
          tmo_nxt   = '0;
`endif
        end
      end
      ST_WAIT_IRQ: begin
        if (irq) begin
          addr_nxt  = RD_ADDR;
          cs_nxt    = 1'b1;
          rd_nxt    = 1'b1;
          state_nxt = ST_RD;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_nxt = '0;
          rerr_nxt  = 1'b1;
          rv_nxt    = 1'b1;
          state_nxt = ST_OUT;
        end else begin
          tmo_nxt   = tmo_cnt + TMO_W'(1);
        end
`endif
      end
      ST_RD: begin
        if (!av_wait_request) begin
          rdata_nxt = av_read_data;
          rerr_nxt  = 1'b0;
          rv_nxt    = 1'b1;
          rd_nxt    = 1'b0;
          cs_nxt    = 1'b0;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          rv_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      av_address     <= '0;
      av_chip_select <= 1'b0;
      av_write       <= 1'b0;
      av_write_data  <= '0;
      av_read        <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      av_address     <= addr_nxt;
      av_chip_select <= cs_nxt;
      av_write       <= wr_nxt;
      av_write_data  <= wdata_nxt;
      av_read        <= rd_nxt;
      res_valid      <= rv_nxt;
      res_data       <= rdata_nxt;
      res_err        <= rerr_nxt;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_nxt;
    end
  end
`endif

endmodule
